// File: rtl/e2prom_pkg.sv
// Shared types and constants for the EEPROM read/write self-test sequencer.
// Used by e2prom_rw_test_ctrl and e2prom_wr_delay.
package e2prom_pkg;

    typedef enum logic [3:0] {
        IDLE,
        WR_REQ,
        WR_WAIT,
        WR_DELAY,
        RD_REQ,
        RD_WAIT,
        CHECK,
        PASS,
        FAIL
    } e2prom_state_t;

    localparam logic I2C_RD = 1'b1;
    localparam logic I2C_WR = 1'b0;

    // EEPROM internal write-cycle time in clk cycles
    localparam logic [13:0] WR_WAIT_MAX_DEF = 14'd5000;

endpackage

// File: rtl/e2prom_wr_delay.sv
// Loadable down-counter: i_load arms it with i_load_val, o_expire pulses for one
// cycle when it reaches zero. Generic enough to time I2C bus phases as well.
module e2prom_wr_delay #(
    parameter int W = 14
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    output logic         o_expire
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt    <= '0;
            o_expire <= 1'b0;
        end else begin
            o_expire <= 1'b0;
            if (i_load) begin
                r_cnt    <= i_load_val;
                // a zero load expires immediately instead of hanging
                o_expire <= (i_load_val == '0);
            end else if (r_cnt != '0) begin
                r_cnt    <= r_cnt - W'(1);
                o_expire <= (r_cnt == W'(1));
            end
        end
    end

endmodule

// File: rtl/e2prom_rw_test_ctrl.sv
// EEPROM self-test sequencer: writes A[7:0] to addresses 0..MAX_BYTE-1 through the
// I2C byte driver, reads them back and compares. Optional macro: RETRY_ON_NACK_EN.
module e2prom_rw_test_ctrl
    import e2prom_pkg::*;
#(
    parameter logic [15:0] MAX_BYTE    = 16'd256,
    parameter logic [13:0] WR_WAIT_MAX = WR_WAIT_MAX_DEF
`ifdef RETRY_ON_NACK_EN
    ,
    parameter logic [1:0]  RETRY_MAX   = 2'd3
`endif
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_start,
    output logic        o_busy,
    output logic        o_i2c_exec,
    output logic        o_i2c_rh_wl,
    output logic [15:0] o_i2c_addr,
    output logic [7:0]  o_i2c_data_w,
    input  logic [7:0]  i_i2c_data_r,
    input  logic        i_i2c_done,
    input  logic        i_i2c_ack,
    output logic        o_rw_done,
    output logic        o_rw_result
);

    localparam logic [15:0] LAST_ADDR = MAX_BYTE - 16'd1;

    e2prom_state_t r_state;
    logic [15:0]   r_addr;
    logic [7:0]    r_data_rd;
    logic          w_dly_load;
    logic          w_dly_expire;
`ifdef RETRY_ON_NACK_EN
    logic [1:0]    r_retry;
`endif

    assign w_dly_load = (r_state == WR_WAIT) && i_i2c_done && !i_i2c_ack;

    e2prom_wr_delay #(.W(14)) u_wr_delay (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_load     (w_dly_load),
        .i_load_val (WR_WAIT_MAX),
        .o_expire   (w_dly_expire)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state      <= IDLE;
            r_addr       <= '0;
            r_data_rd    <= '0;
            o_busy       <= 1'b0;
            o_i2c_exec   <= 1'b0;
            o_i2c_rh_wl  <= 1'b0;
            o_i2c_addr   <= '0;
            o_i2c_data_w <= '0;
            o_rw_done    <= 1'b0;
            o_rw_result  <= 1'b0;
`ifdef RETRY_ON_NACK_EN
            r_retry      <= '0;
`endif
        end else begin
            o_i2c_exec <= 1'b0;
            o_rw_done  <= 1'b0;
            case (r_state)
                IDLE: if (i_start) begin
                    r_state     <= WR_REQ;
                    r_addr      <= '0;
                    o_rw_result <= 1'b0;
                    o_busy      <= 1'b1;
`ifdef RETRY_ON_NACK_EN
                    r_retry     <= '0;
`endif
                end
                WR_REQ: begin
                    o_i2c_exec   <= 1'b1;
                    o_i2c_rh_wl  <= I2C_WR;
                    o_i2c_addr   <= r_addr;
                    o_i2c_data_w <= r_addr[7:0];
                    r_state      <= WR_WAIT;
                end
                WR_WAIT: if (i_i2c_done) begin
                    if (!i_i2c_ack) begin
                        r_state <= WR_DELAY;
`ifdef RETRY_ON_NACK_EN
                        r_retry <= '0;
                    end else if (r_retry + 2'd1 != RETRY_MAX) begin
                        r_retry <= r_retry + 2'd1;
                        r_state <= WR_REQ;
`endif
                    end else begin
                        r_state     <= FAIL;
                        o_rw_done   <= 1'b1;
                        o_rw_result <= 1'b0;
                    end
                end
                WR_DELAY: if (w_dly_expire) begin
                    if (r_addr == LAST_ADDR) begin
                        r_addr  <= '0;
                        r_state <= RD_REQ;
                    end else begin
                        r_addr  <= r_addr + 16'd1;
                        r_state <= WR_REQ;
                    end
                end
                RD_REQ: begin
                    o_i2c_exec  <= 1'b1;
                    o_i2c_rh_wl <= I2C_RD;
                    o_i2c_addr  <= r_addr;
                    r_state     <= RD_WAIT;
                end
                RD_WAIT: if (i_i2c_done) begin
                    if (!i_i2c_ack) begin
                        r_data_rd <= i_i2c_data_r;
                        r_state   <= CHECK;
`ifdef RETRY_ON_NACK_EN
                        r_retry   <= '0;
                    end else if (r_retry + 2'd1 != RETRY_MAX) begin
                        r_retry <= r_retry + 2'd1;
                        r_state <= RD_REQ;
`endif
                    end else begin
                        r_state     <= FAIL;
                        o_rw_done   <= 1'b1;
                        o_rw_result <= 1'b0;
                    end
                end
                CHECK: begin
                    if (r_data_rd != r_addr[7:0]) begin
                        r_state     <= FAIL;
                        o_rw_done   <= 1'b1;
                        o_rw_result <= 1'b0;
                    end else if (r_addr == LAST_ADDR) begin
                        r_state     <= PASS;
                        o_rw_done   <= 1'b1;
                        o_rw_result <= 1'b1;
                    end else begin
                        r_addr  <= r_addr + 16'd1;
                        r_state <= RD_REQ;
                    end
                end
                PASS, FAIL: begin
                    r_state <= IDLE;
                    o_busy  <= 1'b0;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_e2prom_rw_test_ctrl.sv
// Bench for e2prom_rw_test_ctrl: I2C driver/memory model plus a transaction-level
// expectation list that every exec, held output and rw_done pulse is checked against.
module tb_e2prom_rw_test_ctrl;

    localparam int NB   = 4;
    localparam int WW   = 8;
    localparam int RMAX = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        busy, exec, rh, rw_done, rw_result;
    logic [15:0] addr;
    logic [7:0]  dw;
    logic [7:0]  dr = 8'h00;
    logic        i2c_done = 1'b0;
    logic        i2c_ack = 1'b0;

    always #5 clk = ~clk;

    e2prom_rw_test_ctrl #(.MAX_BYTE(16'd4), .WR_WAIT_MAX(14'd8)) u_dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_start      (start),
        .o_busy       (busy),
        .o_i2c_exec   (exec),
        .o_i2c_rh_wl  (rh),
        .o_i2c_addr   (addr),
        .o_i2c_data_w (dw),
        .i_i2c_data_r (dr),
        .i_i2c_done   (i2c_done),
        .i_i2c_ack    (i2c_ack),
        .o_rw_done    (rw_done),
        .o_rw_result  (rw_result)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // expected transaction list for the current run
    logic        exp_rd   [0:63];
    logic [15:0] exp_addr [0:63];
    int          exp_n = 0;
    int          exp_i = 0;
    logic        exp_pass = 1'b1;

    task automatic add_exp(input logic rd, input int a);
        exp_rd[exp_n]   = rd;
        exp_addr[exp_n] = 16'(a);
        exp_n++;
    endtask

    task automatic build_model(input int nack_addr, input int nack_n, input int bad_addr);
        int tries;
        exp_n = 0;
        exp_pass = 1'b1;
        for (int a = 0; a < NB; a++) begin
            tries = 0;
            forever begin
                add_exp(1'b0, a);
                if (a != nack_addr || tries >= nack_n) break;
                tries++;
`ifdef RETRY_ON_NACK_EN
                if (tries >= RMAX) begin exp_pass = 1'b0; return; end
`else
                exp_pass = 1'b0;
                return;
`endif
            end
        end
        for (int a = 0; a < NB; a++) begin
            add_exp(1'b1, a);
            if (a == bad_addr) begin exp_pass = 1'b0; return; end
        end
    endtask

    // driver configuration and monitor state
    int          cfg_nack_addr = -1, cfg_nack_n = 0, cfg_bad_addr = -1, nack_used = 0;
    logic [7:0]  mem [0:255];
    int          spur_cnt = 0, spur_seen = 0;
    int          cyc = 0, drv_cnt = 0, exec_cnt = 0, last_wr_cyc = 0;
    bit          outstanding = 0, drv_pend = 0, run_active = 0, done_seen = 0;
    bit          busy_drop_chk = 0, last_wr_ack = 0;
    logic        cap_rd = 1'b0;
    logic [15:0] cap_addr = '0;
    logic [7:0]  cap_dw = '0;
    logic        last_result = 1'b0;

    always @(negedge clk) begin
        cyc++;
        i2c_done = 1'b0;
        i2c_ack  = 1'b0;
        if (rst) begin
            outstanding = 0; drv_pend = 0; run_active = 0;
            busy_drop_chk = 0; last_wr_ack = 0;
        end else begin
            if (busy_drop_chk) begin
                chk("busy_after_done", busy, 0);
                busy_drop_chk = 0;
            end
            if (outstanding)
                chk("hold_while_outstanding", {rh, addr, dw}, {cap_rd, cap_addr, cap_dw});
            if (drv_pend) begin
                drv_cnt--;
                if (drv_cnt == 0) begin
                    drv_pend = 0;
                    outstanding = 0;
                    i2c_done = 1'b1;
                    if (!cap_rd && int'(cap_addr) == cfg_nack_addr && nack_used < cfg_nack_n) begin
                        i2c_ack = 1'b1;
                        nack_used++;
                    end else if (!cap_rd) begin
                        mem[cap_addr[7:0]] = cap_dw;
                        last_wr_ack = 1;
                        last_wr_cyc = cyc;
                    end else begin
                        dr = (int'(cap_addr) == cfg_bad_addr) ? 8'h55 : mem[cap_addr[7:0]];
                    end
                end
            end else if (spur_cnt != spur_seen) begin
                i2c_done = 1'b1;
                spur_seen++;
            end
            if (exec) begin
                chk("busy_at_exec", busy, 1);
                chk("exec_no_overlap", outstanding, 0);
                chk("exec_in_budget", exp_i < exp_n, 1);
                if (exp_i < exp_n) begin
                    chk("exec_rw", rh, exp_rd[exp_i]);
                    chk("exec_addr", addr, exp_addr[exp_i]);
                    if (!exp_rd[exp_i])
                        chk("exec_wdata", dw, exp_addr[exp_i] % 256);
                    exp_i++;
                end
                if (last_wr_ack) begin
                    chk("wr_gap_ok", (cyc - last_wr_cyc - 1) >= WW, 1);
                    last_wr_ack = 0;
                end
                cap_rd = rh; cap_addr = addr; cap_dw = dw;
                outstanding = 1; drv_pend = 1; drv_cnt = 3;
                exec_cnt++;
            end
            if (rw_done) begin
                chk("done_expected", run_active, 1);
                if (run_active) begin
                    chk("done_all_execs", exp_i, exp_n);
                    chk("done_result", rw_result, exp_pass);
                end
                last_result = rw_result;
                run_active = 0;
                done_seen = 1;
                busy_drop_chk = 1;
            end
        end
    end

    task automatic begin_test(input int nack_addr, input int nack_n, input int bad_addr);
        cfg_nack_addr = nack_addr; cfg_nack_n = nack_n; cfg_bad_addr = bad_addr;
        nack_used = 0; exec_cnt = 0; exp_i = 0; done_seen = 0; last_wr_ack = 0;
        for (int i = 0; i < 256; i++) mem[i] = 8'hAA;
        build_model(nack_addr, nack_n, bad_addr);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        run_active = 1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", busy, 1);
    endtask

    task automatic wait_done();
        for (int k = 0; k < 3000 && !done_seen; k++) @(negedge clk);
        chk("run_timeout", done_seen, 1);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #1;
        chk("rst_outputs", {busy, exec, rh, addr, dw, rw_done, rw_result}, 0);
        repeat (3) @(negedge clk);
        #2 rst = 1'b0;

        // 1: clean run
        begin_test(-1, 0, -1);
        chk("t1_model_len", exp_n, 8);
        pulse_start();
        wait_done();
        chk("t1_execs", exec_cnt, 8);
        chk("t1_result", last_result, 1);

        // 2: bad read data at address 2
        begin_test(-1, 0, 2);
        pulse_start();
        wait_done();
        chk("t2_execs", exec_cnt, 7);
        chk("t2_result", last_result, 0);
        chk("t2_result_held", rw_result, 0);

        // 3: single NACK on write of address 1
        begin_test(1, 1, -1);
        pulse_start();
        wait_done();
`ifdef RETRY_ON_NACK_EN
        chk("t3_execs", exec_cnt, 9);
        chk("t3_result", last_result, 1);
`else
        chk("t3_execs", exec_cnt, 2);
        chk("t3_result", last_result, 0);
`endif

        // 4: two NACKs on write of address 1
        begin_test(1, 2, -1);
        pulse_start();
        wait_done();
`ifdef RETRY_ON_NACK_EN
        chk("t4_execs", exec_cnt, 10);
        chk("t4_result", last_result, 1);
`else
        chk("t4_execs", exec_cnt, 2);
        chk("t4_result", last_result, 0);
`endif

        // 5: reset while waiting on the read of address 1, then a clean restart
        begin_test(-1, 0, -1);
        pulse_start();
        for (int k = 0; k < 3000 && exec_cnt < 6; k++) @(negedge clk);
        chk("t5_reached_rd1", exec_cnt, 6);
        @(negedge clk);
        #3 rst = 1'b1;
        #1 chk("t5_reset_outputs", {busy, exec, rh, addr, dw, rw_done, rw_result}, 0);
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;
        begin_test(-1, 0, -1);
        pulse_start();
        wait_done();
        chk("t5_restart_execs", exec_cnt, 8);
        chk("t5_restart_result", last_result, 1);

        // 6: spurious done in IDLE, second start during WR_DELAY
        begin_test(-1, 0, -1);
        spur_cnt++;
        repeat (3) @(negedge clk);
        chk("t6_idle_no_exec", exec_cnt, 0);
        chk("t6_idle_busy", busy, 0);
        pulse_start();
        for (int k = 0; k < 3000 && !(exec_cnt >= 2 && !outstanding); k++) @(negedge clk);
        repeat (2) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("t6_busy_kept", busy, 1);
        wait_done();
        chk("t6_execs", exec_cnt, 8);
        chk("t6_result", last_result, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
